// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, sampling helpers and
// framing constants common to the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned TX_STOP_BITS   = 1;
  localparam logic        TX_IDLE_LEVEL  = 1'b1;
  localparam logic        TX_START_LEVEL = 1'b0;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned tick_div(input int unsigned clock_rate,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    int unsigned per_tick;
    per_tick = baud_rate * oversample;
    return (clock_rate + per_tick / 2) / per_tick;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every DIV clocks. restart_i
// realigns the phase so the next tick lands DIV clocks later.
module uart_baud_tick #(
  parameter int unsigned DIV = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || restart_i) begin
      cnt_q  <= '0;
      tick_o <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_o <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + CW'(1);
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1 UART receiver with majority-vote sampling, false-start
// rejection, framing-error and break detection.
module uart_rx_oversampled #(
  parameter int unsigned CLOCK_RATE    = 25000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned RX_OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_Rx_Data,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Done,
  output logic       o_Rx_Active,
  output logic       o_Frame_Err,
  output logic       o_Break
);
  import uart_pkg::*;

  localparam int unsigned TICK_DIV = tick_div(CLOCK_RATE, BAUD_RATE, RX_OVERSAMPLE);
  localparam logic [4:0]  TK_S0    = 5'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [4:0]  TK_S1    = 5'(RX_OVERSAMPLE / 2);
  localparam logic [4:0]  TK_S2    = 5'(RX_OVERSAMPLE / 2 + 1);
  localparam logic [4:0]  TK_END   = 5'(RX_OVERSAMPLE);

  logic                      rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]                warm_q;
  logic                      armed_q;
  rx_state_t                 state_q;
  logic [4:0]                tick_cnt_q;
  logic [2:0]                bit_cnt_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [1:0]                samples_q;
  logic [7:0]                byte_q;
  logic                      done_q, active_q, ferr_q, break_q;

  logic       tick_s, start_edge_s, sample_s, decide_s, bit_end_s, vote_s, restart_s;
  logic [4:0] tick_num_s;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .restart_i (restart_s),
    .tick_o    (tick_s)
  );

  // The line only counts as armed once a genuine high has passed the synchronizer.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      warm_q    <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_Rx_Data;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      warm_q    <= {warm_q[0], 1'b1};
      if (warm_q[1] && rx_sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    start_edge_s = armed_q & rx_prev_q & ~rx_sync_q;
    tick_num_s   = tick_cnt_q + 5'd1;
    sample_s     = tick_s && ((tick_num_s == TK_S0) || (tick_num_s == TK_S1));
    decide_s     = tick_s && (tick_num_s == TK_S2);
    bit_end_s    = tick_s && (tick_num_s == TK_END);
    vote_s       = maj3({samples_q, rx_sync_q});
    restart_s    = 1'b0;
    case (state_q)
      ST_IDLE:      restart_s = start_edge_s;
      ST_STOP:      restart_s = decide_s && (!vote_s || start_edge_s);
      ST_WAIT_IDLE: restart_s = ~rx_sync_q;
      default:      restart_s = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samples_q  <= '0;
      byte_q     <= 8'h00;
      done_q     <= 1'b0;
      active_q   <= 1'b0;
      ferr_q     <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      if (restart_s) begin
        tick_cnt_q <= '0;
      end else if (tick_s) begin
        tick_cnt_q <= bit_end_s ? 5'd0 : tick_num_s;
      end
      if (sample_s) begin
        samples_q <= {samples_q[0], rx_sync_q};
      end
      case (state_q)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_q  <= ST_START;
            active_q <= 1'b1;
          end
        end
        ST_START: begin
          if (decide_s && vote_s) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
          end else if (bit_end_s) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= 3'd0;
          end
        end
        ST_DATA: begin
          if (decide_s) begin
            shift_q <= {vote_s, shift_q[7:1]};
          end
          if (bit_end_s) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end
        end
        // A start edge coinciding with the stop decision opens the next frame directly.
        ST_STOP: begin
          if (decide_s) begin
            if (vote_s) begin
              byte_q <= shift_q;
              done_q <= 1'b1;
              if (start_edge_s) begin
                state_q <= ST_START;
              end else begin
                state_q  <= ST_IDLE;
                active_q <= 1'b0;
              end
            end else begin
              ferr_q  <= 1'b1;
              break_q <= (shift_q == 8'h00);
              state_q <= ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (bit_end_s) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            break_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Done   = done_q;
  assign o_Rx_Active = active_q;
  assign o_Frame_Err = ferr_q;
  assign o_Break     = break_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: table vectors, randomized
// frames against a frame-level model, and hand-written corner sequences.
module tb_uart_rx_oversampled;

  localparam int BIT_CLKS = 217;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_done;
    logic       exp_ferr;
    logic       exp_brk;
    logic [7:0] exp_byte;
  } vec_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_done, rx_active, frame_err, brk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, ferr_cnt = 0, act_rise = 0, done_long = 0, ferr_long = 0;
  logic done_prev = 1'b0, ferr_prev = 1'b0, act_prev = 1'b0;
  logic [7:0] got_q[$];

  uart_rx_oversampled dut (
    .clk         (clk),
    .reset       (reset),
    .i_Rx_Data   (rx),
    .o_Rx_Byte   (rx_byte),
    .o_Rx_Done   (rx_done),
    .o_Rx_Active (rx_active),
    .o_Frame_Err (frame_err),
    .o_Break     (brk)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      got_q.push_back(rx_byte);
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (rx_done === 1'b1 && done_prev) done_long <= done_long + 1;
    if (frame_err === 1'b1 && ferr_prev) ferr_long <= ferr_long + 1;
    if (rx_active === 1'b1 && !act_prev) act_rise <= act_rise + 1;
    done_prev <= (rx_done === 1'b1);
    ferr_prev <= (frame_err === 1'b1);
    act_prev  <= (rx_active === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line(d[i], BIT_CLKS);
    line(stop, BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop,
                           input logic e_done, input logic e_ferr, input logic e_brk,
                           input logic [7:0] e_byte, input int gap);
    int d0, f0;
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(d, stop);
    check({tag, " done"}, done_cnt - d0, {31'd0, e_done});
    check({tag, " ferr"}, ferr_cnt - f0, {31'd0, e_ferr});
    check({tag, " byte"}, rx_byte, e_byte);
    check({tag, " break"}, brk, e_brk);
    repeat (gap) @(negedge clk);
    check({tag, " break_clr"}, brk, 1'b0);
    check({tag, " idle"}, rx_active, 1'b0);
  endtask

  vec_t       tbl[6];
  logic [7:0] model_byte;
  logic [7:0] b2b[8];

  initial begin
    int d0, f0, a0;
    logic [7:0] d;
    logic       s;
    logic [31:0] act;

    tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55};
    tbl[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA3};
    tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA3};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF};
    tbl[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF};
    b2b    = '{8'h01, 8'h10, 8'h22, 8'h32, 8'h55, 8'hAA, 8'hAB, 8'h88};

    // Reset with the line low; a low line must not look like a start edge.
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check("rst byte", rx_byte, 8'h00);
    check("rst done", rx_done, 1'b0);
    check("rst active", rx_active, 1'b0);
    check("rst ferr", frame_err, 1'b0);
    check("rst break", brk, 1'b0);
    line(1'b0, 60);
    check("low after reset no start", act_rise, 0);
    line(1'b1, 60);
    check("low after reset idle", rx_active, 1'b0);
    model_byte = 8'h00;

    foreach (tbl[i]) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].data, tbl[i].stop, tbl[i].exp_done,
                tbl[i].exp_ferr, tbl[i].exp_brk, tbl[i].exp_byte, 300);
      if (tbl[i].stop) model_byte = tbl[i].data;
    end

    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 3) != 0);
      if (s) model_byte = d;
      run_frame($sformatf("rnd%0d", n), d, s, s, !s, (!s && d == 8'h00),
                model_byte, $urandom_range(250, 400));
    end

    // Short low glitch: false start, no output pulses.
    d0 = done_cnt; f0 = ferr_cnt; a0 = act_rise;
    line(1'b0, 60);
    line(1'b1, 400);
    check("glitch active pulse", act_rise - a0, 1);
    check("glitch active clr", rx_active, 1'b0);
    check("glitch done", done_cnt - d0, 0);
    check("glitch ferr", ferr_cnt - f0, 0);

    // Break: line low for 20 bit times, then high.
    d0 = done_cnt;
    line(1'b0, 2300);
    check("break set", brk, 1'b1);
    line(1'b0, 20 * BIT_CLKS - 2300);
    check("break held low", brk, 1'b1);
    line(1'b1, 150);
    check("break held high", brk, 1'b1);
    line(1'b1, 150);
    check("break clr", brk, 1'b0);
    check("break active clr", rx_active, 1'b0);
    check("break done", done_cnt - d0, 0);

    // Back-to-back frames with no idle gap.
    got_q.delete();
    f0 = ferr_cnt;
    for (int i = 0; i < 8; i++) send_frame(b2b[i], 1'b1);
    line(1'b1, 50);
    check("b2b count", got_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      act = (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD;
      check($sformatf("b2b byte%0d", i), act, {24'd0, b2b[i]});
    end
    check("b2b ferr", ferr_cnt - f0, 0);
    line(1'b1, 200);

    // One-clk reset during data bit 4 of 8'hFF, then 8'h5A.
    d0 = done_cnt; f0 = ferr_cnt;
    line(1'b0, BIT_CLKS);
    line(1'b1, 4 * BIT_CLKS + 60);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst active", rx_active, 1'b0);
    check("midrst byte", rx_byte, 8'h00);
    line(1'b1, BIT_CLKS - 61 + 4 * BIT_CLKS + 300);
    check("midrst done", done_cnt - d0, 0);
    check("midrst ferr", ferr_cnt - f0, 0);
    send_frame(8'h5A, 1'b1);
    line(1'b1, 20);
    check("after rst done", done_cnt - d0, 1);
    check("after rst byte", rx_byte, 8'h5A);

    check("done width", done_long, 0);
    check("ferr width", ferr_long, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 25000000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line bit rate.
REQ-003 SHALL have parameter RX_OVERSAMPLE, default 16: sample ticks per bit; legal values are 8 or 16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_Rx_Data, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port o_Rx_Byte, output, 8 bits: last correctly framed byte.
REQ-008 SHALL have port o_Rx_Done, output, 1 bit: one-clk pulse when o_Rx_Byte updates.
REQ-009 SHALL have port o_Rx_Active, output, 1 bit: high from start-bit detection to end of frame.
REQ-010 SHALL have port o_Frame_Err, output, 1 bit: one-clk pulse on a low stop bit.
REQ-011 SHALL have port o_Break, output, 1 bit: level, high while a break condition persists.

Function
REQ-012 SHALL pass i_Rx_Data through a 2-flop synchronizer; both flops SHALL reset to 1.
REQ-013 SHALL generate a sample tick every TICK_DIV clk, where TICK_DIV = round(CLOCK_RATE / (BAUD_RATE*RX_OVERSAMPLE)), giving 14 at the defaults.
REQ-014 SHALL restart the tick divider and tick counter on start-bit detection so that bit timing aligns to the falling edge.
REQ-015 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-016 IDLE: a synchronized 1->0 transition SHALL move to START and assert o_Rx_Active.
REQ-017 Each bit value SHALL be the 2-of-3 majority of the samples at ticks OS/2-1, OS/2 and OS/2+1 (7, 8, 9 for OS=16).
REQ-018 START: a majority of 1 SHALL be a false start and return to IDLE with no output pulse; a majority of 0 SHALL proceed to DATA.
REQ-019 DATA: SHALL shift 8 bits, LSB first, with a 3-bit bit counter; it SHALL move to STOP after bit 7.
REQ-020 STOP, majority 1: o_Rx_Byte SHALL update and o_Rx_Done SHALL pulse for exactly one clk, on the clk after the tick-OS/2+1 decision; the FSM SHALL then go to IDLE.
REQ-021 STOP, majority 0: o_Frame_Err SHALL pulse for one clk and o_Rx_Byte SHALL hold its old value.
REQ-022 After a STOP with majority 0, the FSM SHALL go to WAIT_IDLE; if all 8 data bits were also 0, o_Break SHALL assert.
REQ-023 WAIT_IDLE SHALL stay until the synchronized line reads 1 for one full bit time, then deassert o_Break and go to IDLE.
REQ-024 A falling edge during STOP (back-to-back frames) SHALL be accepted as the next start immediately after the stop decision.
REQ-025 o_Rx_Active SHALL deassert on the clk the FSM enters IDLE.

Reset
REQ-026 On reset the FSM SHALL go to IDLE and the divider, tick counter, bit counter and shift register SHALL clear.
REQ-027 On reset o_Rx_Byte SHALL be 8'h00, and o_Rx_Done, o_Rx_Active, o_Frame_Err and o_Break SHALL be 0.
REQ-028 Reset mid-frame SHALL abort the frame with no pulse on any output; a low line after reset SHALL NOT count as a start edge until a 1 has been seen.

Structure
REQ-029 The state enum and the majority-vote function SHALL live in the shared package uart_pkg, alongside the TX-side constants.
REQ-030 The tick generator SHALL be a separate sub-module, uart_baud_tick, reusable by the TX path.
REQ-031 Total RTL SHALL be 120-400 lines.

Verification
REQ-032 Defaults, bytes 8'h55 then 8'hA3 sent at 217 clk/bit, 1 stop bit: o_Rx_Done SHALL pulse twice, o_Rx_Byte SHALL read 55 then A3, and o_Frame_Err SHALL stay 0.
REQ-033 Low glitch of 60 clk on an idle line: o_Rx_Active SHALL pulse and then return to 0, with no o_Rx_Done and no o_Frame_Err.
REQ-034 Byte 8'h3C sent with stop bit = 0: o_Frame_Err SHALL pulse once and o_Rx_Byte SHALL keep its previous value.
REQ-035 Line held low for 20 bit times, then high: o_Break SHALL assert once the stop bit has been decided and deassert one bit time after the line returns high; o_Rx_Done SHALL stay 0.
REQ-036 Eight back-to-back bytes 01,10,22,32,55,AA,AB,88 with zero idle gap: all eight SHALL be received in order.
REQ-037 Reset asserted for one clk during data bit 4 of 8'hFF: no o_Rx_Done, and the next frame 8'h5A SHALL be received correctly.
